// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: fetch/data two-master front end for the memory unit start/busy handshake
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_done,
    input  logic        mem_busy,
    input  logic [31:0] mem_q,
    output logic [26:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_we,
    output logic        mem_start,
    input  logic        i_req,
    input  logic [26:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_q,
    input  logic        d_req,
    input  logic [26:0] d_addr,
    input  logic [31:0] d_data,
    input  logic        d_we,
    output logic        d_ack,
    output logic [31:0] d_q,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
    state_t state, state_n;
    logic [3:0] starve, starve_n;
    logic [15:0] tcnt, tcnt_n;
    logic gnt_i, gnt_i_n;
    logic [26:0] mem_addr_n;
    logic [31:0] mem_data_n, i_q_n, d_q_n, rdata;
    logic mem_we_n, mem_start_n, i_ack_n, d_ack_n, timeout_err_n;
    logic grant, pick_i, busy_phase, timed_out, finish, abort, ends;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            starve <= '0;
            tcnt <= '0;
            gnt_i <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_we <= 1'b0;
            mem_start <= 1'b0;
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            i_q <= '0;
            d_q <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_n;
            starve <= starve_n;
            tcnt <= tcnt_n;
            gnt_i <= gnt_i_n;
            mem_addr <= mem_addr_n;
            mem_data <= mem_data_n;
            mem_we <= mem_we_n;
            mem_start <= mem_start_n;
            i_ack <= i_ack_n;
            d_ack <= d_ack_n;
            i_q <= i_q_n;
            d_q <= d_q_n;
            timeout_err <= timeout_err_n;
        end
    end
    always_comb begin
        grant = state == IDLE && init_done && (i_req || d_req);
        pick_i = i_req && (!d_req || starve == 4'(STARVE_LIMIT));
        busy_phase = state == START || state == WAIT;
        timed_out = TIMEOUT != 0 && busy_phase && 16'(tcnt + 16'd1) == 16'(TIMEOUT);
        finish = state == WAIT && !mem_busy;
        abort = timed_out && !finish;
        ends = finish || abort;
        state_n = state;
        case (state)
            IDLE:    state_n = grant ? START : IDLE;
            START:   state_n = abort ? DONE : mem_busy ? WAIT : START;
            WAIT:    state_n = ends ? DONE : WAIT;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        rdata = finish ? mem_q : 32'd0;
        gnt_i_n = grant ? pick_i : gnt_i;
        mem_addr_n = grant ? (pick_i ? i_addr : d_addr) : mem_addr;
        mem_data_n = grant ? (pick_i ? 32'd0 : d_data) : mem_data;
        mem_we_n = grant ? (!pick_i && d_we) : (mem_we && !ends);
        mem_start_n = grant || (mem_start && !ends);
        i_ack_n = ends && gnt_i;
        d_ack_n = ends && !gnt_i;
        i_q_n = i_ack_n ? rdata : i_q;
        d_q_n = d_ack_n ? rdata : d_q;
        timeout_err_n = timeout_err || abort;
        // a data grant only counts against fetch while fetch is actually waiting
        starve_n = !grant ? starve : (pick_i || !i_req) ? 4'd0 :
                   starve == 4'(STARVE_LIMIT) ? starve : starve + 4'd1;
        tcnt_n = grant ? 16'd0 : busy_phase ? tcnt + 16'd1 : tcnt;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench with a negedge memory-unit model
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic reset, init_done, mem_busy, mem_we, mem_start;
    logic [31:0] mem_q, mem_data, i_q, d_q, d_data;
    logic [26:0] mem_addr, i_addr, d_addr;
    logic i_req, i_ack, d_req, d_we, d_ack, timeout_err;
    logic t_reset, t_init, t_busy, t_mwe, t_start, t_ireq, t_iack, t_dreq, t_dwe, t_dack, t_err;
    logic [31:0] t_mq, t_mdata, t_iq, t_ddata, t_dq;
    logic [26:0] t_maddr, t_iaddr, t_daddr;
    typedef struct {
        logic        port;
        logic [26:0] addr;
        logic [31:0] q;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int n_chk = 0, n_fail = 0;
    int busy_len = 1, bcnt = 0, busy_hi = 0, start_lo = 0, low, hi, n;
    logic served;

    always #5 clk = ~clk;

    mem_bus_arbiter u_dut (
        .clk(clk), .reset(reset), .init_done(init_done), .mem_busy(mem_busy), .mem_q(mem_q),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_start(mem_start),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_q(i_q),
        .d_req(d_req), .d_addr(d_addr), .d_data(d_data), .d_we(d_we), .d_ack(d_ack), .d_q(d_q),
        .timeout_err(timeout_err)
    );

    mem_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) u_to (
        .clk(clk), .reset(t_reset), .init_done(t_init), .mem_busy(t_busy), .mem_q(t_mq),
        .mem_addr(t_maddr), .mem_data(t_mdata), .mem_we(t_mwe), .mem_start(t_start),
        .i_req(t_ireq), .i_addr(t_iaddr), .i_ack(t_iack), .i_q(t_iq),
        .d_req(t_dreq), .d_addr(t_daddr), .d_data(t_ddata), .d_we(t_dwe), .d_ack(t_dack), .d_q(t_dq),
        .timeout_err(t_err)
    );

    function automatic logic [31:0] mq(input logic [26:0] a);
        return a == 27'hC02422 ? 32'hDEADBEEF : {5'h15, a};
    endfunction

    // memory unit: raises busy on the negedge after start, holds it busy_len negedges
    always @(negedge clk) begin
        if (reset) begin
            mem_busy <= 1'b0;
            bcnt <= 0;
            served <= 1'b0;
            mem_q <= '0;
        end else if (mem_busy) begin
            if (bcnt <= 1) begin
                mem_busy <= 1'b0;
                served <= 1'b1;
            end else bcnt <= bcnt - 1;
        end else if (!mem_start) served <= 1'b0;
        else if (!served) begin
            mem_busy <= 1'b1;
            bcnt <= busy_len;
            mem_q <= mq(mem_addr);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (i_ack || d_ack) begin
            chk("one_ack", {31'd0, i_ack & d_ack}, 32'd0);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack: got i_ack=%b d_ack=%b expected none", i_ack, d_ack);
            end else begin
                e = sb.pop_front();
                chk("ack_port", {31'd0, i_ack}, {31'd0, e.port});
                chk("ack_addr", {5'd0, mem_addr}, {5'd0, e.addr});
                chk("ack_q", e.port ? i_q : d_q, e.q);
            end
        end
    end

    task automatic push_exp(input logic p, input logic [26:0] a);
        sb.push_back('{p, a, mq(a)});
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(posedge clk);
            #1;
            if (mem_busy) busy_hi++;
            if (mem_busy && !mem_start) start_lo++;
            k++;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d acks outstanding after %0d cycles, required 0", sb.size(), budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; init_done = 0; i_req = 0; i_addr = '0; d_req = 0; d_addr = '0; d_data = '0; d_we = 0;
        t_reset = 1; t_init = 1; t_busy = 0; t_mq = 32'hFFFFFFFF; t_ireq = 0; t_iaddr = '0;
        t_dreq = 0; t_daddr = '0; t_ddata = '0; t_dwe = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start", {31'd0, mem_start}, 0);
        chk("rst_addr", {5'd0, mem_addr}, 0);
        chk("rst_we", {31'd0, mem_we}, 0);
        chk("rst_acks", {30'd0, i_ack, d_ack}, 0);
        chk("rst_iq", i_q, 0);
        chk("rst_dq", d_q, 0);
        chk("rst_err", {31'd0, timeout_err}, 0);
        @(negedge clk);
        reset = 0; t_reset = 0;
        d_addr = 27'hC02422; d_req = 1;
        low = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (mem_start) low++;
        end
        chk("start_before_init", low, 0);
        @(negedge clk);
        init_done = 1;
        push_exp(0, 27'hC02422);
        @(posedge clk);
        #1;
        chk("grant_start", {31'd0, mem_start}, 1);
        chk("grant_addr", {5'd0, mem_addr}, {5'd0, 27'hC02422});
        @(posedge clk);
        #1;
        chk("dack_t1", {31'd0, d_ack}, 0);
        @(posedge clk);
        #1;
        chk("dack_t2", {31'd0, d_ack}, 1);
        chk("dq_t2", d_q, 32'hDEADBEEF);
        @(negedge clk);
        d_req = 0;
        @(posedge clk);
        #1;
        chk("dack_t3", {31'd0, d_ack}, 0);
        drain(20);
        @(negedge clk);
        d_addr = 27'h0000400; d_data = 32'h0BADF00D; d_we = 1; d_req = 1;
        push_exp(0, 27'h0000400);
        @(posedge clk);
        #1;
        chk("wr_we", {31'd0, mem_we}, 1);
        chk("wr_data", mem_data, 32'h0BADF00D);
        drain(20);
        @(negedge clk);
        d_req = 0; d_we = 0;
        chk("wr_we_dropped", {31'd0, mem_we}, 0);
        i_addr = 27'h0001000; i_req = 1;
        push_exp(1, 27'h0001000);
        drain(20);
        @(negedge clk);
        i_req = 0;
        d_addr = 27'h0000100; i_addr = 27'h0000200;
        for (int k = 0; k < 10; k++) push_exp(k % 5 == 4, k % 5 == 4 ? 27'h0000200 : 27'h0000100);
        d_req = 1; i_req = 1;
        drain(200);
        @(negedge clk);
        d_req = 0; i_req = 0;
        busy_len = 300; busy_hi = 0; start_lo = 0;
        d_addr = 27'h0000300; d_req = 1;
        push_exp(0, 27'h0000300);
        drain(400);
        @(negedge clk);
        d_req = 0;
        chk("uart_start_lo", start_lo, 0);
        chk("uart_busy_seen", {31'd0, busy_hi >= 300}, 1);
        chk("uart_err", {31'd0, timeout_err}, 0);
        busy_len = 50;
        d_addr = 27'h0000500; d_req = 1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
        chk("rstw_start", {31'd0, mem_start}, 0);
        chk("rstw_addr", {5'd0, mem_addr}, 0);
        chk("rstw_acks", {30'd0, i_ack, d_ack}, 0);
        chk("rstw_iq", i_q, 0);
        chk("rstw_dq", d_q, 0);
        @(negedge clk);
        reset = 0; busy_len = 1;
        push_exp(0, 27'h0000500);
        drain(20);
        @(negedge clk);
        d_req = 0;
        t_daddr = 27'h0000077; t_dreq = 1;
        @(posedge clk);
        #1;
        hi = 0; n = 0;
        while (t_start && n < 100) begin
            hi++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("to_start_cycles", hi, 16);
        chk("to_dack", {31'd0, t_dack}, 1);
        chk("to_iack", {31'd0, t_iack}, 0);
        chk("to_dq", t_dq, 0);
        chk("to_err", {31'd0, t_err}, 1);
        @(negedge clk);
        t_dreq = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("to_err_sticky", {31'd0, t_err}, 1);
        chk("to_dack_pulse", {31'd0, t_dack}, 0);
        @(negedge clk);
        t_reset = 1;
        @(posedge clk);
        #1;
        chk("to_err_reset", {31'd0, t_err}, 0);
        t_reset = 0;
        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
